m_demultiplexor1_4_stream: RTL and testbench
============================================

Name: m_demultiplexor1_4_stream

Overview:
- Registered 1-to-4 demultiplexor, the distribution-side counterpart of the 4-to-1 multiplexor in the datapath.
- Accepts one 32-bit word plus a 2-bit destination select per valid/ready transfer.
- Holds the word in a single-entry output register and presents it on exactly one of four output channels until that channel accepts it.
- Keeps a per-channel delivered-word counter for debug and verification.

Parameters:
- WIDTH, 32: data width of input and every output channel.
- CNT_W, 8: width of each per-channel delivered counter; counters wrap modulo 2^CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  word to route.
- in_select  input  2  destination channel 0..3.
- in_valid  input  1  in_data/in_select valid.
- in_ready  output  1  block accepts the input this cycle.
- out_data  output  WIDTH  registered word, shared by all channels.
- out_valid  output  4  one-hot (or zero) channel valid.
- out_ready  input  4  per-channel accept.
- cnt0..cnt3  output  CNT_W each  words delivered on channel 0..3.
- busy  output  1  the output register holds an undelivered word.

Behaviour:
- Reset (rst_n low, asynchronous, any cycle):
  - out_valid=4'b0000, busy=0, out_data=0, cnt0..cnt3=0.
  - in_ready is combinational and reads 1 while rst_n is high and the register is empty.
  - A word in flight at reset is discarded and never counted.
- State: EMPTY (busy=0) and FULL (busy=1); the held select is stored as sel_q.
- Output encoding:
  - out_valid[i] = busy && sel_q==i; at most one bit is ever set.
  - out_data = the held word; its value is unspecified-stable (it keeps the last word) while EMPTY.
- Output handshake: deliver = busy && out_ready[sel_q]. out_ready bits of the non-selected channels are ignored.
- Input handshake:
  - in_ready = !busy || deliver (pass-through bubble-free).
  - accept = in_valid && in_ready.
- Transitions on the rising edge:
  - EMPTY, accept: load in_data and in_select, go to FULL. Latency is 1 cycle; the word appears on out_valid the cycle after acceptance.
  - FULL, deliver, no accept: go to EMPTY.
  - FULL, deliver and accept in the same cycle: load the new word/select, stay FULL. Back-to-back throughput is 1 word/cycle, including a switch to a different channel.
  - FULL, no deliver: hold data and sel_q unchanged. in_ready=0, so the input is stalled.
  - EMPTY, no accept: stay EMPTY.
- Input stability: in_data and in_select must be stable while in_valid=1 and in_ready=0. The block samples only on accept.
- Counters:
  - cnt[sel_q] increments by 1 on each deliver cycle, wrapping from 2^CNT_W-1 to 0.
  - At most one counter changes per cycle.
  - Counter updates are visible the cycle after deliver.
- in_valid without in_ready does not change any state.
- Output valid never drops without delivery: once out_valid[i] rises, it stays high and out_data stays stable until out_ready[i] is seen high.

Test Plan:
- Reset then single transfer:
  - Stimulus: rst_n low 2 cycles, then in_valid=1, in_data=32'hFFFF0000, in_select=2, out_ready=4'b1111.
  - Required: next cycle out_valid=4'b0100 and out_data=32'hFFFF0000; the cycle after, cnt2=1 and the other counters are 0.
- Stall hold:
  - Stimulus: load 32'h0000FFFF to select 1 with out_ready=0 for 5 cycles.
  - Required: out_valid=4'b0010, busy=1, in_ready=0 and out_data constant throughout.
  - Then out_ready[1]=1: delivered in that cycle, cnt1=1 the next cycle.
- Non-selected ready ignored:
  - Stimulus: word held for channel 3, out_ready=4'b0111.
  - Required: no delivery, all counters unchanged, in_ready=0.
- Back-to-back channel sweep:
  - Stimulus: in_valid held high with select cycling 0,1,2,3 and data ~data each cycle, out_ready=4'b1111.
  - Required: one delivery per cycle with out_valid shifting 0001→0010→0100→1000 one cycle after each input; after 40 cycles, cnt0..cnt3=10 each.
- Counter wrap:
  - Stimulus: deliver 256 words to channel 0 with CNT_W=8.
  - Required: cnt0 reads 0 afterwards; cnt1..cnt3 remain 0.
- Reset mid-operation:
  - Stimulus: rst_n asserted asynchronously (off the clock edge) while FULL for channel 2.
  - Required: out_valid=0 and busy=0 immediately; cnt2 is not incremented; the first word after reset release is routed normally.

Source files
------------

// File: rtl/m_demultiplexor1_4_stream.sv
// Registered 1-to-4 stream demultiplexor: one-entry output register routed to one of
// four valid/ready channels, with a wrapping delivered-word counter per channel.
module m_demultiplexor1_4_stream #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  output logic             busy
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  logic busy_s;
  logic deliver_s;
  logic accept_s;
  logic in_ready_s;

  // Handshake qualifiers; the output register frees up in the same cycle it delivers.
  always_comb begin
    busy_s     = (state_q == ST_FULL);
    deliver_s  = busy_s & out_ready[sel_q];
    in_ready_s = rst_n & (~busy_s | deliver_s);
    accept_s   = in_valid & in_ready_s;
  end

  // Next-state: load on accept, release on deliver, count each delivery.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          state_d = ST_FULL;
          sel_d   = in_select;
          data_d  = in_data;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (deliver_s) begin
          cnt_d[sel_q] = cnt_q[sel_q] + {{(CNT_W-1){1'b0}}, 1'b1};
          if (accept_s) begin
            state_d = ST_FULL;
            sel_d   = in_select;
            data_d  = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State, held word and counters; an in-flight word is dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      sel_q   <= 2'd0;
      data_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // One-hot channel valid decoded straight from registered state.
  always_comb begin
    out_valid = 4'b0000;
    if (busy_s) begin
      out_valid[sel_q] = 1'b1;
    end else begin
      out_valid = 4'b0000;
    end
  end

  assign in_ready = in_ready_s;
  assign out_data = data_q;
  assign busy     = busy_s;
  assign cnt0     = cnt_q[0];
  assign cnt1     = cnt_q[1];
  assign cnt2     = cnt_q[2];
  assign cnt3     = cnt_q[3];

endmodule

// File: tb/tb_m_demultiplexor1_4_stream.sv
// Directed bench for m_demultiplexor1_4_stream: a driver pushes expected (word, channel)
// pairs on acceptance, a monitor pops and compares them on every delivery.
module tb_m_demultiplexor1_4_stream;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       sel;
  } item_t;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_select;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
  logic             busy;

  item_t sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  m_demultiplexor1_4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_select(in_select), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_cnts(input string name, input int e0, input int e1, input int e2, input int e3);
    check({name, ".cnt0"}, 64'(cnt0), 64'(e0));
    check({name, ".cnt1"}, 64'(cnt1), 64'(e1));
    check({name, ".cnt2"}, 64'(cnt2), 64'(e2));
    check({name, ".cnt3"}, 64'(cnt3), 64'(e3));
  endtask

  // Monitor: scoreboard pop on delivery plus hold-stability of a pending word.
  logic [3:0]       prev_v;
  logic [WIDTH-1:0] prev_d;
  logic             prev_pend;
  initial begin
    item_t it;
    prev_pend = 1'b0;
    prev_v    = 4'b0000;
    prev_d    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_pend = 1'b0;
      end else begin
        if (prev_pend) begin
          check("hold.valid", 64'(out_valid), 64'(prev_v));
          check("hold.data", 64'(out_data), 64'(prev_d));
        end
        if ((out_valid & out_ready) != 4'b0000) begin
          if (sb_q.size() == 0) begin
            check("sb.unexpected", 64'(out_valid), 64'd0);
          end else begin
            it = sb_q.pop_front();
            check("sb.data", 64'(out_data), 64'(it.data));
            check("sb.chan", 64'(out_valid), 64'(4'b0001 << it.sel));
          end
          prev_pend = 1'b0;
        end else begin
          prev_pend = (out_valid != 4'b0000);
        end
        prev_v = out_valid;
        prev_d = out_data;
      end
    end
  end

  // Offer one word; returns at posedge+1 after acceptance (bounded wait).
  task automatic send(input logic [WIDTH-1:0] d, input logic [1:0] s);
    bit done;
    item_t it;
    done      = 1'b0;
    in_data   = d;
    in_select = s;
    in_valid  = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        it.data = d;
        it.sel  = s;
        sb_q.push_back(it);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("send.timeout", 64'd0, 64'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic [1:0]       prev_sel;
    in_data   = '0;
    in_select = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    rst_n     = 1'b0;

    // Reset then single transfer
    tick(); tick();
    check("rst.out_valid", 64'(out_valid), 64'h0);
    check("rst.busy", 64'(busy), 64'h0);
    check("rst.out_data", 64'(out_data), 64'h0);
    check_cnts("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready", 64'(in_ready), 64'h1);
    send(32'hFFFF0000, 2'd2);
    check("t1.out_valid", 64'(out_valid), 64'h4);
    check("t1.out_data", 64'(out_data), 64'hFFFF0000);
    tick();
    check_cnts("t1", 0, 0, 1, 0);
    check("t1.busy", 64'(busy), 64'h0);

    // Stall hold
    out_ready = 4'b0000;
    send(32'h0000FFFF, 2'd1);
    for (int i = 0; i < 5; i++) begin
      check("t2.out_valid", 64'(out_valid), 64'h2);
      check("t2.busy", 64'(busy), 64'h1);
      check("t2.in_ready", 64'(in_ready), 64'h0);
      check("t2.out_data", 64'(out_data), 64'h0000FFFF);
      tick();
    end
    out_ready = 4'b0010;
    #1;
    check("t2.in_ready_deliver", 64'(in_ready), 64'h1);
    tick();
    check_cnts("t2", 0, 1, 1, 0);
    check("t2.busy_after", 64'(busy), 64'h0);

    // Non-selected ready ignored
    out_ready = 4'b0111;
    send(32'hA5A5C3C3, 2'd3);
    for (int i = 0; i < 3; i++) begin
      check("t3.out_valid", 64'(out_valid), 64'h8);
      check("t3.in_ready", 64'(in_ready), 64'h0);
      check_cnts("t3", 0, 1, 1, 0);
      tick();
    end
    out_ready = 4'b1111;
    tick();
    check_cnts("t3.rel", 0, 1, 1, 1);

    // Back-to-back channel sweep, 40 words
    d = 32'h12345678;
    prev_sel = 2'd0;
    for (int i = 0; i < 40; i++) begin
      item_t it;
      in_data   = d;
      in_select = 2'(i % 4);
      in_valid  = 1'b1;
      @(negedge clk);
      check("t4.in_ready", 64'(in_ready), 64'h1);
      if (i > 0) check("t4.out_valid", 64'(out_valid), 64'(4'b0001 << prev_sel));
      it.data = d;
      it.sel  = 2'(i % 4);
      sb_q.push_back(it);
      prev_sel = 2'(i % 4);
      tick();
      d = ~d;
    end
    in_valid = 1'b0;
    tick();
    check_cnts("t4", 10, 11, 11, 11);
    check("t4.busy", 64'(busy), 64'h0);

    // Counter wrap on channel 0 from a fresh reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    in_select = 2'd0;
    in_valid  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      item_t it;
      in_data = 32'(i);
      @(negedge clk);
      if (in_ready) begin
        it.data = 32'(i);
        it.sel  = 2'd0;
        sb_q.push_back(it);
      end
      tick();
      if (i == 254) check_cnts("t5.pre", 254, 0, 0, 0);
    end
    in_valid = 1'b0;
    tick();
    check_cnts("t5", 0, 0, 0, 0);

    // Reset mid-operation while FULL for channel 2
    out_ready = 4'b0000;
    send(32'hCAFEBABE, 2'd2);
    check("t6.pre_valid", 64'(out_valid), 64'h4);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6.out_valid", 64'(out_valid), 64'h0);
    check("t6.busy", 64'(busy), 64'h0);
    sb_q.delete();
    out_ready = 4'b1111;
    tick();
    check_cnts("t6.rst", 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    tick();
    send(32'h13579BDF, 2'd1);
    check("t6.next_valid", 64'(out_valid), 64'h2);
    check("t6.next_data", 64'(out_data), 64'h13579BDF);
    tick();
    check_cnts("t6", 0, 1, 0, 0);

    tick();
    check("sb.drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
